// File: rtl/sys_input_conditioner.sv
// Front-panel input stage: two-flop synchronizers, a debounced load-button FSM that
// issues a one-cycle load strobe with a captured PC value, and a select-bus stability filter.
module sys_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PC_WIDTH        = 8,
    parameter int SEL_WIDTH       = 8
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 btn_load_raw,
    input  logic [PC_WIDTH-1:0]  sw_pc_raw,
    input  logic [SEL_WIDTH-1:0] sw_sel_raw,
    output logic                 load_pulse,
    output logic [PC_WIDTH-1:0]  pc_val,
    output logic [SEL_WIDTH-1:0] output_sel,
    output logic                 load_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic                 btn_meta_q;
    logic                 btn_s_q;
    logic [PC_WIDTH-1:0]  pc_meta_q;
    logic [PC_WIDTH-1:0]  pc_s_q;
    logic [SEL_WIDTH-1:0] sel_meta_q;
    logic [SEL_WIDTH-1:0] sel_s_q;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SEL_WIDTH-1:0] sel_cand_q;
    logic [CNT_W-1:0]     scnt_q;

    // Two-flop synchronizers; only the second stage feeds downstream logic.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            pc_meta_q  <= '0;
            pc_s_q     <= '0;
            sel_meta_q <= '0;
            sel_s_q    <= '0;
        end else begin
            btn_meta_q <= btn_load_raw;
            btn_s_q    <= btn_meta_q;
            pc_meta_q  <= sw_pc_raw;
            pc_s_q     <= pc_meta_q;
            sel_meta_q <= sw_sel_raw;
            sel_s_q    <= sel_meta_q;
        end
    end

    // Button debounce FSM with registered strobe and PC capture.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            load_pulse <= 1'b0;
            pc_val     <= '0;
        end else begin
            load_pulse <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= HELD;
                        load_pulse <= 1'b1;
                        pc_val     <= pc_s_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_s_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        state_q <= HELD;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high returns to HELD without re-arming the strobe.
                    if (btn_s_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Select filter: a new value must persist unchanged before it reaches output_sel.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            sel_cand_q <= '0;
            scnt_q     <= '0;
            output_sel <= '0;
        end else if (sel_s_q != sel_cand_q) begin
            sel_cand_q <= sel_s_q;
            scnt_q     <= '0;
        end else if (scnt_q == CNT_LAST) begin
            output_sel <= sel_cand_q;
        end else begin
            scnt_q <= scnt_q + CNT_ONE;
        end
    end

    assign load_busy = (state_q != IDLE);

endmodule
